// File: rtl/wb_arbiter_rr2_if.sv
// Wishbone B4 classic point-to-point bundle for the two-master round-robin arbiter.
// The master modport drives the request; the slave modport drives the response.
interface wb_arbiter_rr2_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  logic [AW-1:0]   adr;
  logic [DW-1:0]   dat_w;
  logic [DW-1:0]   dat_r;
  logic [DW/8-1:0] sel;
  logic            we;
  logic            cyc;
  logic            stb;
  logic            ack;
  logic            err;

  modport master (
    output adr, dat_w, sel, we, cyc, stb,
    input  dat_r, ack, err
  );

  modport slave (
    input  adr, dat_w, sel, we, cyc, stb,
    output dat_r, ack, err
  );
endinterface

// File: rtl/wb_arbiter_rr2.sv
// Two-master Wishbone B4 classic arbiter; round-robin, grant held for the whole cyc burst.
// Define WB_ARB_TIMEOUT_EN to add a watchdog that errors out hung slave cycles.
module wb_arbiter_rr2 #(
  parameter int unsigned AW             = 32,
  parameter int unsigned DW             = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                    wb_clk,
  input  logic                    wb_rst,
  wb_arbiter_rr2_if.slave         io_m0,
  wb_arbiter_rr2_if.slave         io_m1,
  wb_arbiter_rr2_if.master        io_s,
  output logic [1:0]              gnt_o
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StGnt0 = 2'd1,
    StGnt1 = 2'd2
  } state_e;

  state_e r_state, w_state_d;
  logic   r_last, w_last_d;   // last master served; the other one wins a tie
  logic   w_timeout;

  logic [AW-1:0]   w_s_adr;
  logic [DW-1:0]   w_s_dat;
  logic [DW/8-1:0] w_s_sel;
  logic            w_s_we;
  logic            w_s_cyc;
  logic            w_s_stb;

  function automatic state_e pick(input logic c0, input logic c1, input logic last);
    if (c0 && c1) return last ? StGnt0 : StGnt1;
    if (c0)       return StGnt0;
    if (c1)       return StGnt1;
    return StIdle;
  endfunction

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      r_state <= StIdle;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_state_d;
      r_last  <= w_last_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_last_d  = r_last;
    unique case (r_state)
      StIdle: w_state_d = pick(io_m0.cyc, io_m1.cyc, r_last);
      StGnt0: begin
        if (!io_m0.cyc) begin
          w_last_d  = 1'b0;
          w_state_d = pick(1'b0, io_m1.cyc, 1'b0);
        end
      end
      StGnt1: begin
        if (!io_m1.cyc) begin
          w_last_d  = 1'b1;
          w_state_d = pick(io_m0.cyc, 1'b0, 1'b1);
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_comb begin
    w_s_adr     = '0;
    w_s_dat     = '0;
    w_s_sel     = '0;
    w_s_we      = 1'b0;
    w_s_cyc     = 1'b0;
    w_s_stb     = 1'b0;
    io_m0.ack   = 1'b0;
    io_m0.err   = 1'b0;
    io_m0.dat_r = '0;
    io_m1.ack   = 1'b0;
    io_m1.err   = 1'b0;
    io_m1.dat_r = '0;
    unique case (r_state)
      StGnt0: begin
        w_s_adr     = io_m0.adr;
        w_s_dat     = io_m0.dat_w;
        w_s_sel     = io_m0.sel;
        w_s_we      = io_m0.we;
        w_s_cyc     = io_m0.cyc;
        w_s_stb     = io_m0.stb;
        io_m0.ack   = io_s.ack;
        io_m0.err   = io_s.err | w_timeout;
        io_m0.dat_r = io_s.dat_r;
      end
      StGnt1: begin
        w_s_adr     = io_m1.adr;
        w_s_dat     = io_m1.dat_w;
        w_s_sel     = io_m1.sel;
        w_s_we      = io_m1.we;
        w_s_cyc     = io_m1.cyc;
        w_s_stb     = io_m1.stb;
        io_m1.ack   = io_s.ack;
        io_m1.err   = io_s.err | w_timeout;
        io_m1.dat_r = io_s.dat_r;
      end
      default: ;
    endcase
  end

  assign io_s.adr   = w_s_adr;
  assign io_s.dat_w = w_s_dat;
  assign io_s.sel   = w_s_sel;
  assign io_s.we    = w_s_we;
  assign io_s.cyc   = w_s_cyc;
  assign io_s.stb   = w_s_stb & ~w_timeout;

  assign gnt_o = {r_state == StGnt1, r_state == StGnt0};

`ifdef WB_ARB_TIMEOUT_EN
  logic [15:0] r_wdog, w_wdog_d;
  logic        w_stall;

  assign w_timeout = (r_state != StIdle) && (r_wdog == 16'(TIMEOUT_CYCLES));
  assign w_stall   = w_s_cyc & w_s_stb & ~w_timeout & ~io_s.ack & ~io_s.err;

  // The timeout cycle itself also clears, so a still-stalled slave re-arms a full window.
  always_comb begin
    w_wdog_d = r_wdog + 16'd1;
    if (w_timeout || (w_state_d != r_state) || !w_stall) w_wdog_d = '0;
  end

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) r_wdog <= '0;
    else        r_wdog <= w_wdog_d;
  end
`else
  logic w_unused_timeout;
  assign w_timeout        = 1'b0;
  assign w_unused_timeout = ^16'(TIMEOUT_CYCLES);
`endif

endmodule

// File: tb/tb_wb_arbiter_rr2.sv
// Randomized and directed bench for wb_arbiter_rr2 against an owner/last-served reference model.
// With WB_ARB_TIMEOUT_EN defined the DUT is built with an 8-cycle watchdog.
module tb_wb_arbiter_rr2;

`ifdef WB_ARB_TIMEOUT_EN
  localparam int ToCycles = 8;
  localparam bit ToEn     = 1'b1;
`else
  localparam int ToCycles = 255;
  localparam bit ToEn     = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic [1:0] gnt_o;

  always #5 clk = ~clk;

  wb_arbiter_rr2_if #(.AW(32), .DW(32)) m0_if ();
  wb_arbiter_rr2_if #(.AW(32), .DW(32)) m1_if ();
  wb_arbiter_rr2_if #(.AW(32), .DW(32)) s_if ();

  wb_arbiter_rr2 #(
    .AW             (32),
    .DW             (32),
    .TIMEOUT_CYCLES (ToCycles)
  ) dut (
    .wb_clk (clk),
    .wb_rst (rst),
    .io_m0  (m0_if),
    .io_m1  (m1_if),
    .io_s   (s_if),
    .gnt_o  (gnt_o)
  );

  logic        m_cyc[2];
  logic        m_stb[2];
  logic        m_we[2];
  logic [31:0] m_adr[2];
  logic [31:0] m_dat[2];
  logic [3:0]  m_sel[2];
  logic        s_ack, s_err;
  logic [31:0] s_dat;

  assign m0_if.cyc   = m_cyc[0];
  assign m0_if.stb   = m_stb[0];
  assign m0_if.we    = m_we[0];
  assign m0_if.adr   = m_adr[0];
  assign m0_if.dat_w = m_dat[0];
  assign m0_if.sel   = m_sel[0];
  assign m1_if.cyc   = m_cyc[1];
  assign m1_if.stb   = m_stb[1];
  assign m1_if.we    = m_we[1];
  assign m1_if.adr   = m_adr[1];
  assign m1_if.dat_w = m_dat[1];
  assign m1_if.sel   = m_sel[1];
  assign s_if.ack    = s_ack;
  assign s_if.err    = s_err;
  assign s_if.dat_r  = s_dat;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: owner -1 = nobody, else master index; last_srv = last master released.
  int owner, last_srv, wd;

  logic [1:0]  smp_gnt;
  logic        smp_m0_ack, smp_m0_err, smp_m1_ack;
  logic [31:0] smp_m0_dat, smp_s_adr;

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    for (int m = 0; m < 2; m++) begin
      m_cyc[m] = 1'b0;
      m_stb[m] = 1'b0;
      m_we[m]  = 1'b0;
      m_sel[m] = 4'hf;
      m_adr[m] = '0;
      m_dat[m] = '0;
    end
    s_ack = 1'b0;
    s_err = 1'b0;
    s_dat = '0;
  endtask

  task automatic model_reset();
    owner    = -1;
    last_srv = 1;
    wd       = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  // Checks one cycle at the falling edge, then advances the model across the rising edge.
  task automatic step();
    logic [1:0]   e_gnt;
    logic [127:0] e_s, e_r0, e_r1;
    int           nxt, nxt_last, nxt_wd;
    bit           to, stalled;
    @(negedge clk);
    to    = ToEn && (owner >= 0) && (wd == ToCycles);
    e_gnt = (owner == 0) ? 2'b01 : (owner == 1) ? 2'b10 : 2'b00;
    e_s   = '0;
    e_r0  = '0;
    e_r1  = '0;
    if (owner >= 0) begin
      e_s = 128'({m_cyc[owner], m_stb[owner] & ~to, m_we[owner], m_sel[owner],
                  m_adr[owner], m_dat[owner]});
      if (owner == 0) e_r0 = 128'({s_ack, s_err | to, s_dat});
      else            e_r1 = 128'({s_ack, s_err | to, s_dat});
    end
    check_val("gnt", 128'(gnt_o), 128'(e_gnt));
    check_val("s_req", 128'({s_if.cyc, s_if.stb, s_if.we, s_if.sel, s_if.adr, s_if.dat_w}), e_s);
    check_val("m0_rsp", 128'({m0_if.ack, m0_if.err, m0_if.dat_r}), e_r0);
    check_val("m1_rsp", 128'({m1_if.ack, m1_if.err, m1_if.dat_r}), e_r1);
    smp_gnt    = gnt_o;
    smp_m0_ack = m0_if.ack;
    smp_m0_err = m0_if.err;
    smp_m0_dat = m0_if.dat_r;
    smp_m1_ack = m1_if.ack;
    smp_s_adr  = s_if.adr;

    stalled  = (owner >= 0) && m_cyc[owner] && m_stb[owner] && !to && !s_ack && !s_err;
    nxt_last = last_srv;
    if (owner >= 0 && m_cyc[owner]) begin
      nxt = owner;
    end else begin
      if (owner >= 0) nxt_last = owner;
      if (m_cyc[0] && m_cyc[1]) nxt = (nxt_last == 0) ? 1 : 0;
      else if (m_cyc[0])        nxt = 0;
      else if (m_cyc[1])        nxt = 1;
      else                      nxt = -1;
    end
    nxt_wd = (to || nxt != owner || !stalled) ? 0 : wd + 1;
    @(posedge clk); #1;
    owner    = nxt;
    last_srv = nxt_last;
    wd       = nxt_wd;
  endtask

  initial begin
    int pulses, first_at;
    rst = 1'b1;
    idle_inputs();
    model_reset();
    #1;
    m_cyc[0] = 1'b1;
    m_stb[0] = 1'b1;
    s_ack    = 1'b1;
    #1;
    check_val("rst_gnt", 128'(gnt_o), 128'(0));
    check_val("rst_s_cyc_stb", 128'({s_if.cyc, s_if.stb}), 128'(0));
    check_val("rst_m0_ack", 128'({m0_if.ack, m0_if.err}), 128'(0));
    idle_inputs();
    @(posedge clk); #1;
    rst = 1'b0;

    // m0 single read, slave acks in the third stb cycle.
    do_reset();
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_adr[0] = 32'h0000_0100;
    step();
    check_val("t1_idle_gnt", 128'(smp_gnt), 128'(0));
    step();
    check_val("t1_gnt", 128'(smp_gnt), 128'(2'b01));
    step();
    s_ack = 1'b1; s_dat = 32'hDEAD_BEEF;
    step();
    check_val("t1_ack", 128'(smp_m0_ack), 128'(1));
    check_val("t1_dat", 128'(smp_m0_dat), 128'(32'hDEAD_BEEF));
    check_val("t1_m1_ack", 128'(smp_m1_ack), 128'(0));
    idle_inputs();
    step();

    // Simultaneous requests out of reset: m0 first, direct handover to m1.
    do_reset();
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_adr[0] = 32'h20;
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_adr[1] = 32'h40;
    step();
    s_ack = 1'b1;
    step();
    check_val("t2_first", 128'(smp_gnt), 128'(2'b01));
    s_ack = 1'b0; m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
    step();
    step();
    check_val("t2_handover", 128'(smp_gnt), 128'(2'b10));
    idle_inputs();
    step();

    // Back-to-back single cycles from both masters alternate strictly.
    do_reset();
    for (int m = 0; m < 2; m++) begin
      m_cyc[m] = 1'b1; m_stb[m] = 1'b1; m_adr[m] = 32'h1000 * (m + 1);
    end
    step();
    for (int i = 0; i < 8; i++) begin
      s_ack = 1'b1;
      step();
      check_val("t3_alt", 128'(smp_gnt), 128'((i % 2 == 0) ? 2'b01 : 2'b10));
      s_ack = 1'b0; m_cyc[i % 2] = 1'b0; m_stb[i % 2] = 1'b0;
      step();
      m_cyc[i % 2] = 1'b1; m_stb[i % 2] = 1'b1;
    end
    idle_inputs();
    step();
    step();

    // m1 read-modify-write at 0x10 stays atomic against a waiting m0.
    do_reset();
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_adr[1] = 32'h10;
    step();
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_adr[0] = 32'h200; m_we[0] = 1'b1;
    for (int ph = 0; ph < 4; ph++) begin
      s_ack    = (ph == 1) || (ph == 3);
      m_stb[1] = (ph != 2);
      m_we[1]  = (ph == 3);
      m_dat[1] = (ph == 3) ? 32'h5A5A_0001 : 32'h0;
      step();
      check_val("t4_gnt", 128'(smp_gnt), 128'(2'b10));
      check_val("t4_adr", 128'(smp_s_adr), 128'(32'h10));
    end
    s_ack = 1'b0; m_cyc[1] = 1'b0; m_stb[1] = 1'b0;
    step();
    step();
    check_val("t4_m0_gnt", 128'(smp_gnt), 128'(2'b01));
    check_val("t4_m0_adr", 128'(smp_s_adr), 128'(32'h200));
    idle_inputs();
    step();

    // Asynchronous reset during GNT1, then m0 wins the first tie.
    do_reset();
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_adr[1] = 32'h80;
    step();
    step();
    check_val("t5_gnt1", 128'(smp_gnt), 128'(2'b10));
    #2;
    rst = 1'b1;
    #1;
    check_val("t5_rst_cyc", 128'({s_if.cyc, s_if.stb}), 128'(0));
    check_val("t5_rst_gnt", 128'(gnt_o), 128'(0));
    model_reset();
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_adr[0] = 32'h90;
    @(posedge clk); #1;
    rst = 1'b0;
    step();
    step();
    check_val("t5_tie", 128'(smp_gnt), 128'(2'b01));
    idle_inputs();
    step();

    // Slave never acks: watchdog pulse (when built in) or endless wait.
    do_reset();
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_adr[0] = 32'h300;
    step();
    pulses   = 0;
    first_at = -1;
    for (int k = 0; k < 15; k++) begin
      step();
      if (smp_m0_err) begin
        pulses++;
        if (first_at < 0) first_at = k;
      end
    end
    check_val("t6_pulses", 128'(pulses), 128'(ToEn ? 1 : 0));
    check_val("t6_when", 128'(first_at), 128'(ToEn ? ToCycles : -1));
    idle_inputs();
    step();

    // Randomized traffic against the model.
    do_reset();
    repeat (400) begin
      for (int m = 0; m < 2; m++) begin
        if (m_cyc[m]) m_cyc[m] = ($urandom_range(0, 99) < 80);
        else          m_cyc[m] = ($urandom_range(0, 99) < 40);
        m_stb[m] = m_cyc[m] && ($urandom_range(0, 99) < 70);
        m_we[m]  = 1'($urandom);
        m_sel[m] = 4'($urandom);
        m_adr[m] = $urandom;
        m_dat[m] = $urandom;
      end
      s_ack = ($urandom_range(0, 99) < 40);
      s_err = !s_ack && ($urandom_range(0, 99) < 5);
      s_dat = $urandom;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
